fir_cfg_axi_master: RTL and testbench
=====================================

Name: fir_cfg_axi_master

Overview:
AXI4-Lite master that programs and runs the FIR through the FIR's AXI4-Lite slave register interface. On a start request it writes TAP_COUNT, then streams N coefficients one by one into the COEFF register. It then writes CONTROL and polls STATUS until the FIR reports done. It sits between a local sequencer or DMA, which supplies coefficients on a valid/ready stream, and the FIR register bank.

Parameters:
C_M_AXI_ADDR_WIDTH, 32, address width
C_M_AXI_DATA_WIDTH, 32, data width (only 32 supported)
BASE_ADDR, 32'h0, FIR register base
MAX_TAPS, 256, largest legal tap_count_in
CTRL_START_VAL, 32'h1, value written to CONTROL
STATUS_DONE_BIT, 0, bit of STATUS meaning done
POLL_GAP, 16, idle cycles between status reads
POLL_LIMIT, 1024, maximum status reads before timeout

Ports:
M_AXI_ACLK  in  1  clock
M_AXI_ARESETN  in  1  reset
M_AXI_AWADDR  out  32  write address
M_AXI_AWPROT  out  3  tied 3'b000
M_AXI_AWVALID  out  1
M_AXI_AWREADY  in  1
M_AXI_WDATA  out  32
M_AXI_WSTRB  out  4  tied 4'hF
M_AXI_WVALID  out  1
M_AXI_WREADY  in  1
M_AXI_BRESP  in  2
M_AXI_BVALID  in  1
M_AXI_BREADY  out  1
M_AXI_ARADDR  out  32
M_AXI_ARPROT  out  3  tied 3'b000
M_AXI_ARVALID  out  1
M_AXI_ARREADY  in  1
M_AXI_RDATA  in  32
M_AXI_RRESP  in  2
M_AXI_RVALID  in  1
M_AXI_RREADY  out  1
start  in  1  one-cycle request
tap_count_in  in  32  number of coefficients
coeff_tdata  in  32  coefficient stream data
coeff_tvalid  in  1
coeff_tready  out  1
busy  out  1  sequence in progress
done  out  1  one-cycle pulse on success
error  out  1  sticky failure flag
status_out  out  32  last STATUS read

Behaviour:
- Clocking and reset: single clock M_AXI_ACLK. Reset is synchronous and active-low on M_AXI_ARESETN.
- Reset values: all VALIDs, BREADY, RREADY, coeff_tready, busy, done and error are 0. All address/data outputs and status_out are 0. Reset mid-transaction drops every VALID at that edge with no completion.
- Register offsets from BASE_ADDR: CONTROL +0x0, STATUS +0x4, TAP_COUNT +0x8, COEFF +0xC.
- States: IDLE, WR_TAPS, FETCH, WR_COEFF, WR_CTRL, POLL_WAIT, RD_STATUS, FINISH, FAIL.
- IDLE:
  - start is sampled only in IDLE and ignored otherwise.
  - On start, latch tap_count_in, clear error, and set busy the next cycle.
  - If tap_count_in > MAX_TAPS, go to FAIL with no AXI traffic.
- Write sub-sequence, used by WR_TAPS, WR_COEFF and WR_CTRL:
  - Assert AWVALID and WVALID in the same cycle, with AWADDR/WDATA stable.
  - Each VALID deasserts on the cycle after its own VALID&READY handshake. AW and W may complete in either order or together.
  - After both handshakes, BREADY=1 until BVALID. BRESP!=2'b00 goes to FAIL; otherwise advance.
  - One transaction outstanding, maximum.
- WR_TAPS writes the latched count. Count 0 goes directly to WR_CTRL; otherwise go to FETCH.
- FETCH:
  - coeff_tready=1 only in FETCH.
  - Capture coeff_tdata on tvalid&tready, then go to WR_COEFF. Wait indefinitely for tvalid.
- WR_COEFF: after the write completes, increment the coefficient counter. If counter==count, go to WR_CTRL; else go to FETCH.
- WR_CTRL: writes CTRL_START_VAL, then goes to RD_STATUS.
- RD_STATUS:
  - Assert ARVALID until ARREADY. Then assert RREADY until RVALID, and load status_out from RDATA.
  - RRESP!=0 goes to FAIL.
  - RDATA[STATUS_DONE_BIT]=1 goes to FINISH; else increment the poll counter.
  - If the counter reaches POLL_LIMIT, go to FAIL; else go to POLL_WAIT.
- POLL_WAIT: wait exactly POLL_GAP cycles, then return to RD_STATUS.
- FINISH: done=1 for one cycle, busy=0, then IDLE.
- FAIL: error=1 (held until the next accepted start), busy=0, no done pulse, then IDLE.
- Counters: coefficient counter is 9 bits; poll counter is 11 bits. Both clear on an accepted start.

Test Plan:
- Slave model with always-ready AW/W/B/AR/R; start with tap_count_in=4, stream 0x11,0x22,0x33,0x44; STATUS reads 0,0,1 -> writes 0x8=4, 0xC=0x11..0x44 in order, 0x0=1; 3 reads; done pulse; status_out=1; error=0.
- Slave with WREADY 3 cycles before AWREADY and 2-cycle-late BVALID -> each VALID held until its own handshake; exactly one write per register; data unchanged while VALID is high.
- tap_count_in=0 -> writes only 0x8=0 then 0x0; coeff_tready never asserts.
- tap_count_in=257 -> error=1 next cycle, no AXI VALID ever high, busy stays low after.
- BRESP=2'b10 on the second coefficient write -> FAIL; no CONTROL write; error sticky until next start, which clears it.
- STATUS never sets done with POLL_LIMIT=4 -> exactly 4 reads spaced by POLL_GAP idle cycles, then error=1. Apply reset during the second read -> ARVALID and RREADY go to 0 at that edge.

Source files
------------

// File: rtl/fir_cfg_axi_master.sv
// AXI4-Lite master that loads tap count and coefficients into the FIR register
// bank, starts the filter and polls STATUS until done, error or poll timeout.
module fir_cfg_axi_master #(
  parameter int                              C_M_AXI_ADDR_WIDTH = 32,
  parameter int                              C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0]   BASE_ADDR          = '0,
  parameter int                              MAX_TAPS           = 256,
  parameter logic [C_M_AXI_DATA_WIDTH-1:0]   CTRL_START_VAL     = 1,
  parameter int                              STATUS_DONE_BIT    = 0,
  parameter int                              POLL_GAP           = 16,
  parameter int                              POLL_LIMIT         = 1024
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESETN,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY,
  input  logic                              start,
  input  logic [31:0]                       tap_count_in,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     coeff_tdata,
  input  logic                              coeff_tvalid,
  output logic                              coeff_tready,
  output logic                              busy,
  output logic                              done,
  output logic                              error,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     status_out
);

  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_CTRL   = BASE_ADDR;
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_STATUS = BASE_ADDR + C_M_AXI_ADDR_WIDTH'(4);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_TAPS   = BASE_ADDR + C_M_AXI_ADDR_WIDTH'(8);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_COEFF  = BASE_ADDR + C_M_AXI_ADDR_WIDTH'(12);

  typedef enum logic [3:0] {
    IDLE, WR_TAPS, FETCH, WR_COEFF, WR_CTRL, POLL_WAIT, RD_STATUS, FINISH, FAIL
  } state_t;

  state_t      state, nxt;
  logic [31:0] count_q;
  logic [8:0]  coeff_cnt;
  logic [10:0] poll_cnt;
  logic [15:0] gap_cnt;
  logic        aw_done, w_done;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic bad_count, coeff_last, poll_last, gap_last;

  function automatic logic is_wr(state_t s);
    return (s == WR_TAPS) || (s == WR_COEFF) || (s == WR_CTRL);
  endfunction

  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign M_AXI_WSTRB  = '1;
  assign coeff_tready = (state == FETCH);

  assign aw_hs = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_hs  = M_AXI_WVALID  & M_AXI_WREADY;
  assign b_hs  = M_AXI_BREADY  & M_AXI_BVALID;
  assign ar_hs = M_AXI_ARVALID & M_AXI_ARREADY;
  assign r_hs  = M_AXI_RREADY  & M_AXI_RVALID;

  assign bad_count  = tap_count_in > 32'(MAX_TAPS);
  assign coeff_last = (32'(coeff_cnt) + 32'd1) == count_q;
  assign poll_last  = (poll_cnt + 11'd1) == 11'(POLL_LIMIT);
  assign gap_last   = gap_cnt == 16'(POLL_GAP - 1);

  always_comb begin
    nxt = state;
    case (state)
      IDLE:      if (start) nxt = bad_count ? FAIL : WR_TAPS;
      WR_TAPS:   if (b_hs) nxt = (M_AXI_BRESP != 2'b00) ? FAIL :
                                 (count_q == 32'd0) ? WR_CTRL : FETCH;
      FETCH:     if (coeff_tvalid) nxt = WR_COEFF;
      WR_COEFF:  if (b_hs) nxt = (M_AXI_BRESP != 2'b00) ? FAIL :
                                 coeff_last ? WR_CTRL : FETCH;
      WR_CTRL:   if (b_hs) nxt = (M_AXI_BRESP != 2'b00) ? FAIL : RD_STATUS;
      RD_STATUS: if (r_hs) begin
                   if (M_AXI_RRESP != 2'b00)              nxt = FAIL;
                   else if (M_AXI_RDATA[STATUS_DONE_BIT]) nxt = FINISH;
                   else if (poll_last)                    nxt = FAIL;
                   else                                   nxt = POLL_WAIT;
                 end
      POLL_WAIT: if (gap_last) nxt = RD_STATUS;
      FINISH:    nxt = IDLE;
      FAIL:      nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      state         <= IDLE;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= '0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      count_q       <= '0;
      coeff_cnt     <= '0;
      poll_cnt      <= '0;
      gap_cnt       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      status_out    <= '0;
    end else begin
      state <= nxt;
      done  <= 1'b0;

      // Write channel: each VALID drops right after its own handshake.
      if (aw_hs) begin
        M_AXI_AWVALID <= 1'b0;
        aw_done       <= 1'b1;
      end
      if (w_hs) begin
        M_AXI_WVALID <= 1'b0;
        w_done       <= 1'b1;
      end
      if (b_hs) begin
        M_AXI_BREADY <= 1'b0;
        aw_done      <= 1'b0;
        w_done       <= 1'b0;
      end else if ((aw_done | aw_hs) && (w_done | w_hs)) begin
        M_AXI_BREADY <= 1'b1;
      end

      if (is_wr(nxt) && (nxt != state)) begin
        M_AXI_AWVALID <= 1'b1;
        M_AXI_WVALID  <= 1'b1;
        case (nxt)
          WR_TAPS: begin
            M_AXI_AWADDR <= ADDR_TAPS;
            M_AXI_WDATA  <= C_M_AXI_DATA_WIDTH'(tap_count_in);
          end
          WR_COEFF: begin
            M_AXI_AWADDR <= ADDR_COEFF;
            M_AXI_WDATA  <= coeff_tdata;
          end
          default: begin
            M_AXI_AWADDR <= ADDR_CTRL;
            M_AXI_WDATA  <= CTRL_START_VAL;
          end
        endcase
      end

      // Read channel: AR first, then R.
      if ((nxt == RD_STATUS) && (state != RD_STATUS)) begin
        M_AXI_ARVALID <= 1'b1;
        M_AXI_ARADDR  <= ADDR_STATUS;
      end
      if (ar_hs) begin
        M_AXI_ARVALID <= 1'b0;
        M_AXI_RREADY  <= 1'b1;
      end
      if (r_hs) begin
        M_AXI_RREADY <= 1'b0;
        status_out   <= M_AXI_RDATA;
      end

      if ((state == IDLE) && start) begin
        count_q   <= tap_count_in;
        coeff_cnt <= '0;
        poll_cnt  <= '0;
        error     <= bad_count;
        busy      <= !bad_count;
      end
      if ((state == WR_COEFF) && b_hs) coeff_cnt <= coeff_cnt + 9'd1;
      if ((state == RD_STATUS) && r_hs) poll_cnt <= poll_cnt + 11'd1;

      if ((nxt == POLL_WAIT) && (state != POLL_WAIT)) gap_cnt <= '0;
      else if (state == POLL_WAIT)                    gap_cnt <= gap_cnt + 16'd1;

      if (nxt == FINISH) begin
        done <= 1'b1;
        busy <= 1'b0;
      end
      if (nxt == FAIL) begin
        error <= 1'b1;
        busy  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fir_cfg_axi_master.sv
// Bench for fir_cfg_axi_master: table of programming runs against a
// configurable AXI4-Lite slave, with a write scoreboard and a reset corner case.
module tb_fir_cfg_axi_master;

  localparam int GAP   = 3;
  localparam int LIMIT = 4;
  localparam int MAXT  = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        aresetn;
  logic [31:0] awaddr, wdata, araddr, rdata, tap_count_in, coeff_tdata, status_out;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;
  logic start, coeff_tvalid, coeff_tready, busy, done, error;

  fir_cfg_axi_master #(.POLL_GAP(GAP), .POLL_LIMIT(LIMIT), .MAX_TAPS(MAXT)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(aresetn),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
    .start(start), .tap_count_in(tap_count_in), .coeff_tdata(coeff_tdata),
    .coeff_tvalid(coeff_tvalid), .coeff_tready(coeff_tready),
    .busy(busy), .done(done), .error(error), .status_out(status_out)
  );

  // Slave model: AW/W ready after a programmable number of VALID cycles,
  // B a programmable delay after both, optional error response on one write.
  int   aw_lat = 0, w_lat = 0, b_lat = 0, err_abs = -1, done_abs = 0;
  logic aw_got, w_got;
  int   aw_cnt, w_cnt, b_cnt, wr_idx, rd_issued;

  assign awready = !aw_got && (aw_cnt >= aw_lat);
  assign wready  = !w_got && (w_cnt >= w_lat);
  assign arready = 1'b1;
  assign rresp   = 2'b00;

  always @(posedge clk) begin
    if (!aresetn) begin
      aw_got <= 1'b0; w_got <= 1'b0; aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
      bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rdata <= '0;
      wr_idx <= 0; rd_issued <= 0;
    end else begin
      if (awvalid && awready) begin aw_got <= 1'b1; aw_cnt <= 0; end
      else if (awvalid && !aw_got) aw_cnt <= aw_cnt + 1;
      if (wvalid && wready) begin w_got <= 1'b1; w_cnt <= 0; end
      else if (wvalid && !w_got) w_cnt <= w_cnt + 1;
      if (bvalid && bready) begin
        bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 0; wr_idx <= wr_idx + 1;
      end else if (aw_got && w_got && !bvalid) begin
        if (b_cnt >= b_lat) begin
          bvalid <= 1'b1;
          bresp  <= (wr_idx == err_abs) ? 2'b10 : 2'b00;
        end else b_cnt <= b_cnt + 1;
      end
      if (arvalid && arready) begin
        rvalid    <= 1'b1;
        rdata     <= {8'hA5, 23'h0, (rd_issued >= done_abs)};
        rd_issued <= rd_issued + 1;
      end else if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  wr_t exp_q[$];

  typedef struct {
    string name;
    int taps, aw_lat, w_lat, b_lat, err_wr, done_at;
    int exp_done, exp_err, exp_reads, exp_fetch;
  } vec_t;
  vec_t vecs[8];

  int n_chk = 0, n_pass = 0;
  int cyc = 0, rd_count, tready_cnt, tready_hi, any_valid, busy_seen, done_cnt, proto_err;
  int last_r, have_r, feed_k;
  int gaps[$];
  logic [31:0] cap_addr, cap_data;

  function automatic logic [31:0] coeff_val(int k);
    return 32'h11 * 32'(k + 1);
  endfunction

  function automatic logic [31:0] status_word(int d);
    return {8'hA5, 23'h0, d[0]};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
  endtask

  task automatic monitor();
    logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
    logic [31:0] p_awa, p_wd;
    wr_t e;
    p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0; p_awa = 0; p_wd = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!aresetn) begin
        p_awv = 0; p_wv = 0; p_arv = 0;
      end else begin
        if (p_awv && !p_awr && (!awvalid || awaddr !== p_awa)) proto_err++;
        if (p_awv && p_awr && awvalid) proto_err++;
        if (p_wv && !p_wr && (!wvalid || wdata !== p_wd)) proto_err++;
        if (p_wv && p_wr && wvalid) proto_err++;
        if (p_arv && p_arr && arvalid) proto_err++;
        if (awvalid && awready) cap_addr = awaddr;
        if (wvalid && wready) cap_data = wdata;
        if (bvalid && bready) begin
          if (exp_q.size() == 0) chk("unexpected_write", cap_addr, 32'hFFFF_FFFF);
          else begin
            e = exp_q.pop_front();
            chk("write_addr", cap_addr, e.addr);
            chk("write_data", cap_data, e.data);
          end
        end
        if (rvalid && rready) begin rd_count++; last_r = cyc; have_r = 1; end
        if (arvalid && !p_arv && have_r != 0) gaps.push_back(cyc - last_r - 1);
        if (coeff_tvalid && coeff_tready) tready_cnt++;
        if (coeff_tready) tready_hi++;
        if (awvalid || wvalid || arvalid) any_valid++;
        if (busy) busy_seen = 1;
        if (done) done_cnt++;
        p_awv = awvalid; p_awr = awready; p_awa = awaddr;
        p_wv = wvalid; p_wr = wready; p_wd = wdata;
        p_arv = arvalid; p_arr = arready;
      end
    end
  endtask

  task automatic feeder();
    forever begin
      @(negedge clk);
      if (coeff_tvalid && coeff_tready) begin
        @(posedge clk);
        #1;
        feed_k++;
        coeff_tdata = coeff_val(feed_k);
      end
    end
  endtask

  task automatic clear_mon();
    rd_count = 0; tready_cnt = 0; tready_hi = 0; any_valid = 0;
    busy_seen = 0; done_cnt = 0; proto_err = 0; have_r = 0; gaps.delete();
  endtask

  task automatic run_vec(input vec_t v);
    int nw, fin, badgap;
    wr_t e;
    aw_lat = v.aw_lat; w_lat = v.w_lat; b_lat = v.b_lat;
    err_abs  = (v.err_wr < 0) ? -1 : wr_idx + v.err_wr;
    done_abs = rd_issued + v.done_at;
    clear_mon();
    if (v.taps <= MAXT) begin
      nw = (v.err_wr >= 0) ? v.err_wr + 1 : v.taps + 2;
      for (int i = 0; i < nw; i++) begin
        if (i == 0)           begin e.addr = 32'h8; e.data = 32'(v.taps); end
        else if (i <= v.taps) begin e.addr = 32'hC; e.data = coeff_val(i - 1); end
        else                  begin e.addr = 32'h0; e.data = 32'h1; end
        exp_q.push_back(e);
      end
    end
    feed_k = 0; coeff_tdata = coeff_val(0); coeff_tvalid = 1'b1;
    @(negedge clk); start = 1'b1; tap_count_in = 32'(v.taps);
    @(negedge clk); start = 1'b0;
    chk({v.name, "_busy_next"}, 32'(busy), 32'(v.taps <= MAXT));
    chk({v.name, "_err_next"}, 32'(error), 32'(v.taps > MAXT));
    fin = 0;
    for (int c = 0; c < 20000 && fin == 0; c++) begin
      if (!busy && (done || done_cnt > 0 || error)) fin = 1;
      else @(negedge clk);
    end
    chk({v.name, "_completes"}, 32'(fin), 32'd1);
    @(negedge clk);
    chk({v.name, "_done_pulses"}, 32'(done_cnt), 32'(v.exp_done));
    chk({v.name, "_error"}, 32'(error), 32'(v.exp_err));
    chk({v.name, "_reads"}, 32'(rd_count), 32'(v.exp_reads));
    chk({v.name, "_fetches"}, 32'(tready_cnt), 32'(v.exp_fetch));
    chk({v.name, "_writes_left"}, 32'(exp_q.size()), 32'd0);
    chk({v.name, "_protocol"}, 32'(proto_err), 32'd0);
    if (v.taps > MAXT) begin
      chk({v.name, "_no_axi"}, 32'(any_valid), 32'd0);
      chk({v.name, "_never_busy"}, 32'(busy_seen), 32'd0);
    end
    if (v.taps == 0) chk({v.name, "_no_tready"}, 32'(tready_hi), 32'd0);
    if (v.exp_reads > 0) begin
      chk({v.name, "_status_out"}, status_out, status_word(v.exp_done));
      badgap = 0;
      foreach (gaps[i]) if (gaps[i] != GAP) badgap++;
      chk({v.name, "_gap_count"}, 32'(gaps.size()), 32'(v.exp_reads - 1));
      chk({v.name, "_gap_len"}, 32'(badgap), 32'd0);
    end
    repeat (3) @(negedge clk);
    chk({v.name, "_err_sticky"}, 32'(error), 32'(v.exp_err));
    chk({v.name, "_idle_busy"}, 32'(busy), 32'd0);
    coeff_tvalid = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    int found;
    wr_t e;
    aresetn = 1'b0; start = 1'b0; tap_count_in = '0; coeff_tdata = '0; coeff_tvalid = 1'b0;
    cap_addr = '0; cap_data = '0; feed_k = 0;
    clear_mon();
    fork
      monitor();
      feeder();
    join_none

    //            name         taps aw w  b  errwr done  done err reads fetch
    vecs[0] = '{"normal4",     4,   0, 0, 0, -1,   2,    1,   0,  3,    4};
    vecs[1] = '{"skewed4",     4,   4, 1, 2, -1,   0,    1,   0,  1,    4};
    vecs[2] = '{"zero_taps",   0,   0, 0, 0, -1,   1,    1,   0,  2,    0};
    vecs[3] = '{"too_many",    257, 0, 0, 0, -1,   0,    0,   1,  0,    0};
    vecs[4] = '{"bresp_err",   4,   0, 0, 1,  2,   0,    0,   1,  0,    2};
    vecs[5] = '{"one_tap",     1,   2, 0, 0, -1,   0,    1,   0,  1,    1};
    vecs[6] = '{"poll_timeout",2,   0, 0, 0, -1,   99,   0,   1,  4,    2};
    vecs[7] = '{"max_taps",    256, 1, 0, 0, -1,   0,    1,   0,  1,    256};

    repeat (3) @(negedge clk);
    chk("rst_valids", {28'h0, awvalid, wvalid, arvalid, bready}, 32'h0);
    chk("rst_rready_tready", {30'h0, rready, coeff_tready}, 32'h0);
    chk("rst_flags", {29'h0, busy, done, error}, 32'h0);
    chk("rst_awaddr", awaddr, 32'h0);
    chk("rst_wdata", wdata, 32'h0);
    chk("rst_araddr", araddr, 32'h0);
    chk("rst_status_out", status_out, 32'h0);
    chk("tied_prot_strb", {25'h0, awprot, arprot, wstrb[0]}, 32'h1);
    aresetn = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset while the second STATUS read is on the AR channel.
    aw_lat = 0; w_lat = 0; b_lat = 0; err_abs = -1; done_abs = rd_issued + 1000;
    clear_mon();
    e.addr = 32'h8; e.data = 32'h0; exp_q.push_back(e);
    e.addr = 32'h0; e.data = 32'h1; exp_q.push_back(e);
    @(negedge clk); start = 1'b1; tap_count_in = 32'h0;
    @(negedge clk); start = 1'b0;
    found = 0;
    for (int c = 0; c < 2000 && found == 0; c++) begin
      if (rd_count == 1 && arvalid) found = 1;
      else @(negedge clk);
    end
    chk("rst_mid_second_read_seen", 32'(found), 32'd1);
    aresetn = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_arvalid", 32'(arvalid), 32'd0);
    chk("rst_mid_rready", 32'(rready), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    @(negedge clk);
    aresetn = 1'b1;
    chk("rst_mid_writes_left", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_mid_idle", {29'h0, busy, error, arvalid}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
